// File: rtl/hr_rd_capture.sv
// hr_rd_capture: HyperRAM read-capture sequencer assembling RWDS-qualified 16-bit words per burst
module hr_rd_capture #(
  parameter int TIMEOUT_CYC = 64,
  parameter int LEN_BITS    = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rd_start,
  input  logic [LEN_BITS-1:0] rd_len,
  input  logic [7:0]          dq_ris,
  input  logic [7:0]          dq_fal,
  input  logic                rwds_ris,
  input  logic                rwds_fal,
  output logic                busy,
  output logic                cap_en,
  output logic [15:0]         rd_dout,
  output logic                rd_dout_vld,
  output logic                rd_done,
  output logic                rd_timeout
);
  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [GW-1:0] gap_q, gap_d, gap_inc;
  logic [15:0] dout_q, dout_d;
  logic vld_q, vld_d, done_q, done_d, to_q, to_d, busy_q, busy_d;
  logic strobe, active;
  // Next-state: accept a burst, take one word per strobe, count strobe-less cycles toward abort.
  // Both completion and abort pass through DONE so busy falls one cycle after the pulse.
  always_comb begin
    strobe  = rwds_ris & ~rwds_fal;
    active  = (state_q == WAIT) || (state_q == XFER);
    cnt_inc = cnt_q + LEN_BITS'(1);
    gap_inc = (gap_q == GAP_MAX) ? gap_q : gap_q + GW'(1);
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (rd_start && rd_len != '0) begin
        state_d = WAIT;
        len_d   = rd_len;
        cnt_d   = '0;
        gap_d   = '0;
      end
    end else if (active && strobe) begin
      dout_d  = {dq_ris, dq_fal};
      vld_d   = 1'b1;
      cnt_d   = cnt_inc;
      gap_d   = '0;
      done_d  = (cnt_inc == len_q);
      state_d = (cnt_inc == len_q) ? DONE : XFER;
    end else if (active) begin
      gap_d   = gap_inc;
      to_d    = (gap_inc == GAP_MAX);
      state_d = (gap_inc == GAP_MAX) ? DONE : state_q;
    end else begin
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);
  end
  // Register state, counters and every output; reset clears all without emitting pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end
  assign busy        = busy_q;
  assign cap_en      = busy_q;
  assign rd_dout     = dout_q;
  assign rd_dout_vld = vld_q;
  assign rd_done     = done_q;
  assign rd_timeout  = to_q;
endmodule

// File: tb/tb_hr_rd_capture.sv
// tb_hr_rd_capture: directed and random checks of hr_rd_capture against a burst-level model
module tb_hr_rd_capture;
  localparam int TO = 64;
  localparam int LB = 6;
  logic clk = 1'b0, reset_n = 1'b0, rd_start = 1'b0;
  logic [LB-1:0] rd_len = '0;
  logic [7:0] dq_ris = '0, dq_fal = '0;
  logic rwds_ris = 1'b0, rwds_fal = 1'b0;
  logic busy, cap_en, rd_dout_vld, rd_done, rd_timeout;
  logic [15:0] rd_dout;
  int total = 0, bad = 0;
  int n_vld, n_done, n_to, cyc_n, to_at, start_at;
  logic [15:0] got[$];
  bit m_act, m_tail, m_vld, m_done, m_to;
  int m_left, m_quiet;
  logic [15:0] m_dout;

  always #5 clk = ~clk;

  hr_rd_capture #(.TIMEOUT_CYC(TO), .LEN_BITS(LB)) dut (
    .clk(clk), .reset_n(reset_n), .rd_start(rd_start), .rd_len(rd_len),
    .dq_ris(dq_ris), .dq_fal(dq_fal), .rwds_ris(rwds_ris), .rwds_fal(rwds_fal),
    .busy(busy), .cap_en(cap_en), .rd_dout(rd_dout), .rd_dout_vld(rd_dout_vld),
    .rd_done(rd_done), .rd_timeout(rd_timeout)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_tail = 0; m_vld = 0; m_done = 0; m_to = 0;
    m_left = 0; m_quiet = 0; m_dout = '0;
  endtask

  // Burst-level view: words still owed, strobe-less run length, and a one-cycle tail after finishing.
  task automatic model_step();
    m_vld = 0; m_done = 0; m_to = 0;
    if (m_tail) begin
      m_tail = 0; m_act = 0;
    end else if (!m_act) begin
      if (rd_start && rd_len != 0) begin
        m_act = 1; m_left = int'(rd_len); m_quiet = 0;
      end
    end else if (rwds_ris && !rwds_fal) begin
      m_dout = {dq_ris, dq_fal}; m_vld = 1; m_left--; m_quiet = 0;
      if (m_left == 0) begin m_done = 1; m_tail = 1; end
    end else begin
      m_quiet++;
      if (m_quiet == TO) begin m_to = 1; m_tail = 1; end
    end
  endtask

  task automatic cyc(input bit st, input int len, input bit rr, input bit rf, input logic [15:0] d);
    rd_start = st; rd_len = LB'(len); rwds_ris = rr; rwds_fal = rf;
    dq_ris = d[15:8]; dq_fal = d[7:0];
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    #1;
    chk("busy", {15'd0, busy}, {15'd0, m_act});
    chk("cap_en", {15'd0, cap_en}, {15'd0, m_act});
    chk("vld", {15'd0, rd_dout_vld}, {15'd0, m_vld});
    chk("done", {15'd0, rd_done}, {15'd0, m_done});
    chk("timeout", {15'd0, rd_timeout}, {15'd0, m_to});
    chk("dout", rd_dout, m_dout);
    cyc_n++;
    if (rd_dout_vld) begin n_vld++; got.push_back(rd_dout); end
    if (rd_done) n_done++;
    if (rd_timeout) begin n_to++; to_at = cyc_n; end
    @(negedge clk);
  endtask

  task automatic clr();
    n_vld = 0; n_done = 0; n_to = 0; to_at = -1; got.delete();
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      r = $urandom_range(0, 2);
      cyc(0, 0, r == 1, r != 0, 16'($urandom));
    end
  endtask

  task automatic strobe(input logic [15:0] d);
    cyc(0, 0, 1, 0, d);
  endtask

  task automatic start(input int len);
    start_at = cyc_n + 1;
    cyc(1, len, 0, 0, 16'($urandom));
  endtask

  initial begin
    model_reset();
    cyc_n = 0;
    clr();
    @(negedge clk);
    for (int i = 0; i < 4; i++) cyc(1'($urandom), $urandom_range(1, 5), 1, 0, 16'($urandom));
    reset_n = 1'b1;
    quiet(2);
    chk("reset_vld_count", 16'(n_vld), 16'd0);

    clr();
    start(1);
    quiet(3);
    strobe(16'hA53C);
    chk("sw_dout", rd_dout, 16'hA53C);
    chk("sw_vld", {15'd0, rd_dout_vld}, 16'd1);
    chk("sw_done", {15'd0, rd_done}, 16'd1);
    quiet(1);
    chk("sw_busy_after", {15'd0, busy}, 16'd0);
    chk("sw_no_timeout", 16'(n_to), 16'd0);

    clr();
    start(4);
    strobe(16'h0001);
    strobe(16'h0002);
    cyc(0, 0, 0, 0, 16'hFFFF);
    cyc(0, 0, 1, 1, 16'hFFFF);
    strobe(16'h0003);
    strobe(16'h0004);
    chk("gap_done_on_4th", {15'd0, rd_done}, 16'd1);
    strobe(16'h0005);
    quiet(2);
    chk("gap_vld_count", 16'(n_vld), 16'd4);
    chk("gap_done_count", 16'(n_done), 16'd1);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("gap_word", got[i], 16'(i + 1));

    clr();
    start(8);
    quiet(70);
    chk("to_count", 16'(n_to), 16'd1);
    chk("to_latency", 16'(to_at - start_at), 16'(TO));
    chk("to_no_vld", 16'(n_vld), 16'd0);
    chk("to_no_done", 16'(n_done), 16'd0);
    chk("to_busy_after", {15'd0, busy}, 16'd0);

    clr();
    start(8);
    for (int i = 0; i < 3; i++) strobe(16'($urandom));
    quiet(70);
    chk("stall_vld", 16'(n_vld), 16'd3);
    chk("stall_to", 16'(n_to), 16'd1);
    chk("stall_done", 16'(n_done), 16'd0);
    clr();
    start(2);
    strobe(16'h1234);
    strobe(16'h5678);
    quiet(2);
    chk("restart_done", 16'(n_done), 16'd1);
    chk("restart_vld", 16'(n_vld), 16'd2);

    clr();
    cyc(1, 0, 1, 0, 16'hBEEF);
    chk("len0_busy", {15'd0, busy}, 16'd0);
    quiet(1);

    clr();
    start(3);
    strobe(16'h1111);
    cyc(1, 1, 0, 0, 16'h0);
    strobe(16'h2222);
    chk("late_start_no_done", {15'd0, rd_done}, 16'd0);
    strobe(16'h3333);
    chk("late_start_done", {15'd0, rd_done}, 16'd1);
    quiet(2);
    chk("late_vld", 16'(n_vld), 16'd3);

    clr();
    start(10);
    for (int i = 0; i < 4; i++) strobe(16'($urandom));
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_cap_en", {15'd0, cap_en}, 16'd0);
    chk("arst_dout", rd_dout, 16'h0);
    chk("arst_pulses", {14'd0, rd_done, rd_timeout}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    quiet(3);
    chk("arst_no_done", 16'(n_done), 16'd0);
    chk("arst_no_to", 16'(n_to), 16'd0);

    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 3);
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 5),
          r == 0 ? 1'b1 : 1'($urandom), r == 0 ? 1'b0 : 1'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 4),
          $urandom_range(0, 99) == 0, 1'b0, 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
